// File: rtl/post_spi_master.sv
// Byte-oriented SPI mode-0 master (CS/SCK/MOSI out, MISO in); CS is held low across bytes until a LAST byte completes.
// Optional: define POST_SPI_MISO_SYNC_EN for a 2-flop MISO synchronizer with capture moved to the SCK falling edge.
module post_spi_master #(
    parameter logic [15:0] CLK_DIV = 16'd4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       LAST,
    output logic       READY,
    output logic       BUSY,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       CS,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO
);

`ifdef POST_SPI_MISO_SYNC_EN
    // Synchronizer latency needs at least 3 cycles of SCK high before capture.
    localparam logic [15:0] DIV = (CLK_DIV < 16'd3) ? 16'd3 : CLK_DIV;
    localparam bit SYNC_CAPTURE = 1'b1;
`else
    localparam logic [15:0] DIV = (CLK_DIV == 16'd0) ? 16'd1 : CLK_DIV;
    localparam bit SYNC_CAPTURE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCK_HI,
        S_SCK_LO,
        S_HOLD,
        S_TEARDOWN,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_div_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx_shift;
    logic        r_last;
    logic        r_ready;
    logic        r_busy;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_cs;
    logic        r_sck;
    logic        r_mosi;

    logic        w_div_done;
    logic        w_miso;
    logic [7:0]  w_rx_next;

`ifdef POST_SPI_MISO_SYNC_EN
    logic r_miso_s1;
    logic r_miso_s2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= MISO;
            r_miso_s2 <= r_miso_s1;
        end
    end

    assign w_miso = r_miso_s2;
`else
    assign w_miso = MISO;
`endif

    assign w_div_done = (r_div_cnt == DIV - 16'd1);
    assign w_rx_next  = {r_rx_shift[6:0], w_miso};

    assign READY    = r_ready;
    assign BUSY     = r_busy;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;
    assign CS       = r_cs;
    assign SCK      = r_sck;
    assign MOSI     = r_mosi;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx_shift <= '0;
            r_last     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cs       <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == S_IDLE || r_state == S_HOLD) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= w_div_done ? '0 : r_div_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (START) begin
                        r_tx      <= TX_DATA;
                        r_last    <= LAST;
                        r_bit_cnt <= '0;
                        r_cs      <= 1'b0;
                        r_mosi    <= TX_DATA[7];
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP, S_SCK_LO: begin
                    if (w_div_done) begin
                        r_sck   <= 1'b1;
                        r_state <= S_SCK_HI;
                        if (!SYNC_CAPTURE) r_rx_shift <= w_rx_next;
                    end
                end
                S_SCK_HI: begin
                    if (w_div_done) begin
                        r_sck <= 1'b0;
                        if (SYNC_CAPTURE) r_rx_shift <= w_rx_next;
                        if (r_bit_cnt == 3'd7) begin
                            // The synchronized path captures its final bit on this same edge.
                            r_rx_data  <= SYNC_CAPTURE ? w_rx_next : r_rx_shift;
                            r_rx_valid <= 1'b1;
                            if (r_last) begin
                                r_state <= S_TEARDOWN;
                            end else begin
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_HOLD;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= {r_tx[6:0], 1'b0};
                            r_mosi    <= r_tx[6];
                            r_state   <= S_SCK_LO;
                        end
                    end
                end
                S_TEARDOWN: begin
                    if (w_div_done) begin
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_div_done) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
